// File: rtl/rf_writeback_unit.sv
// Register file write-port arbiter: ALU results, buffered
// long-latency results and the pending-destination scoreboard.
module rf_writeback_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_DEPTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [REG_ADDR_WIDTH-1:0]     ll_rd,
  input  logic [DATA_WIDTH-1:0]         ll_data,
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic [REG_ADDR_WIDTH-1:0]     iss_rd,
  input  logic [REG_ADDR_WIDTH-1:0]     ra_a,
  input  logic [REG_ADDR_WIDTH-1:0]     ra_b,
  output logic                          hz_a,
  output logic                          hz_b,
  output logic                          we,
  output logic [REG_ADDR_WIDTH-1:0]     wa,
  output logic [DATA_WIDTH-1:0]         wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } ent_t;

  ent_t                      mem_q [FIFO_DEPTH];
  ent_t                      mem_d [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [REG_DEPTH-1:0]      busy_q, busy_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]     wd_q, wd_d;
  logic                      clr_q, clr_d;

  logic push;
  logic pop;
  ent_t head;

  assign ll_ready   = count_q < FULL;
  assign iss_ready  = !busy_q[iss_rd];
  assign hz_a       = busy_q[ra_a];
  assign hz_b       = busy_q[ra_b];
  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign fifo_count = count_q;

  always_comb begin
    push = ll_valid && ll_ready;
    pop  = !alu_valid && (count_q != '0);
    head = mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: ll_rd, data: ll_data};
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    we_d  = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    clr_d = 1'b0;
    unique case (1'b1)
      alu_valid: begin
        we_d = alu_rd != '0;
        wa_d = alu_rd;
        wd_d = alu_data;
      end
      pop: begin
        we_d  = head.rd != '0;
        wa_d  = head.rd;
        wd_d  = head.data;
        clr_d = 1'b1;
      end
      default: ;
    endcase

    // clear lands on the edge where the register file captures wd
    busy_d = busy_q;
    if (clr_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (iss_valid && iss_ready && iss_rd != '0) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      clr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      clr_q    <= clr_d;
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Scoreboard bench for rf_writeback_unit: a reference FIFO
// model feeds expected writes to a negedge monitor.
module tb_rf_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  ra_a = '0;
  logic [4:0]  ra_b = '0;
  logic        hz_a, hz_b, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  fifo_count;

  rf_writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rd(iss_rd),
    .ra_a(ra_a), .ra_b(ra_b),
    .hz_a(hz_a), .hz_b(hz_b),
    .we(we), .wa(wa), .wd(wd),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t mdl_q[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  // reference: ALU first, else pop the model FIFO;
  // push only if the FIFO was not full before the pop
  task automatic cyc();
    int  n0;
    wr_t e;
    n0 = mdl_q.size();
    if (alu_valid) begin
      if (alu_rd != 0) exp_q.push_back('{alu_rd, alu_data});
    end else if (n0 > 0) begin
      e = mdl_q.pop_front();
      if (e.rd != 0) exp_q.push_back(e);
    end
    if (ll_valid && n0 < 4) mdl_q.push_back('{ll_rd, ll_data});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst && we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, wa}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("wa", {27'd0, wa}, {27'd0, e.rd});
        chk("wd", wd, e.data);
      end
    end
  end

  initial begin
    #12;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("rst_llr", {31'd0, ll_ready}, 32'd1);
    chk("rst_issr", {31'd0, iss_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // ALU write, then rd=0
    alu_valid = 1; alu_rd = 7; alu_data = 32'hDEADBEEF;
    cyc();
    chk("alu_we", {31'd0, we}, 32'd1);
    alu_rd = 0; alu_data = 32'h1234;
    cyc();
    alu_valid = 0;
    chk("alu_x0_we", {31'd0, we}, 32'd0);
    cyc();

    // scoreboard lifecycle on x3
    iss_valid = 1; iss_rd = 3;
    #1 chk("iss3_rdy", {31'd0, iss_ready}, 32'd1);
    cyc();
    iss_valid = 0; ra_a = 3;
    #1;
    chk("hz3_set", {31'd0, hz_a}, 32'd1);
    chk("iss3_blk", {31'd0, iss_ready}, 32'd0);
    ll_valid = 1; ll_rd = 3; ll_data = 32'h55;
    cyc();
    ll_valid = 0;
    cyc();
    chk("ll3_we", {31'd0, we}, 32'd1);
    chk("hz3_during", {31'd0, hz_a}, 32'd1);
    cyc();
    chk("hz3_clear", {31'd0, hz_a}, 32'd0);

    // priority: ALU starves FIFO entry for x4
    iss_valid = 1; iss_rd = 4; ra_b = 4;
    cyc();
    iss_valid = 0;
    ll_valid = 1; ll_rd = 4; ll_data = 32'h44;
    cyc();
    ll_valid = 0;
    alu_valid = 1;
    alu_rd = 1; alu_data = 32'h11; cyc();
    chk("prio_hz4_a", {31'd0, hz_b}, 32'd1);
    alu_rd = 2; alu_data = 32'h22; cyc();
    alu_rd = 6; alu_data = 32'h66; cyc();
    alu_valid = 0;
    chk("prio_hz4_b", {31'd0, hz_b}, 32'd1);
    cyc();
    chk("prio_hz4_c", {31'd0, hz_b}, 32'd1);
    chk("prio_we4", {27'd0, wa}, 32'd4);
    cyc();
    chk("prio_hz4_d", {31'd0, hz_b}, 32'd0);

    // fill with x0 ALU traffic blocking pops
    alu_valid = 1; alu_rd = 0; ll_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ll_rd = 5'(10 + i); ll_data = 32'hA000 + i;
      cyc();
    end
    chk("full_cnt", {29'd0, fifo_count}, 32'd4);
    chk("full_rdy", {31'd0, ll_ready}, 32'd0);
    alu_valid = 0;
    for (int i = 0; i < 10; i++) begin
      ll_rd = 5'(16 + (i % 8)); ll_data = 32'hB000 + i;
      cyc();
    end
    ll_valid = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("wrap_cnt", {29'd0, fifo_count}, 32'd0);

    // issue x9 in the cycle x8 is written back
    iss_valid = 1; iss_rd = 8;
    cyc();
    iss_valid = 0;
    ll_valid = 1; ll_rd = 8; ll_data = 32'h88;
    cyc();
    ll_valid = 0;
    cyc();
    iss_valid = 1; iss_rd = 9; ra_a = 8; ra_b = 9;
    #1;
    chk("sim_iss9_rdy", {31'd0, iss_ready}, 32'd1);
    chk("sim_hz8_a", {31'd0, hz_a}, 32'd1);
    chk("sim_hz9_a", {31'd0, hz_b}, 32'd0);
    cyc();
    iss_valid = 0;
    #1;
    chk("sim_hz8_b", {31'd0, hz_a}, 32'd0);
    chk("sim_hz9_b", {31'd0, hz_b}, 32'd1);
    chk("sim_iss9_blk", {31'd0, iss_ready}, 32'd0);
    cyc();

    // reset mid-stream: busy x5, 3 buffered, we high
    iss_valid = 1; iss_rd = 5;
    cyc();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 0; ll_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ll_rd = 5'(20 + i); ll_data = 32'hC000 + i;
      cyc();
    end
    ll_valid = 0; alu_rd = 7; alu_data = 32'h77;
    cyc();
    alu_valid = 0; ra_a = 5; ra_b = 9;
    chk("pre_rst_cnt", {29'd0, fifo_count}, 32'd3);
    #1 rst = 1'b0;
    exp_q.delete();
    mdl_q.delete();
    #1;
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_llr", {31'd0, ll_ready}, 32'd1);
    chk("mid_rst_issr", {31'd0, iss_ready}, 32'd1);
    chk("mid_rst_hz", {30'd0, hz_a, hz_b}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("post_rst_we", {31'd0, we}, 32'd0);
    chk("exp_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
